// File: rtl/conware_row_engine_pkg.sv
// Shared types and Game-of-Life rule constants
// for the streaming row engine.
package conware_row_engine_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [3:0] LIFE_BIRTH   = 4'd3;
  localparam logic [3:0] LIFE_SURVIVE = 4'd2;

endpackage

// File: rtl/conware_row_engine_life_cell.sv
// One Game-of-Life cell: 3x3 neighbourhood in,
// next state out. Index 1 of mid_i is the cell itself.
module life_cell
  import conware_row_engine_pkg::*;
(
  input  logic [2:0] top_i,
  input  logic [2:0] mid_i,
  input  logic [2:0] bot_i,
  output logic       next_o
);

  logic [3:0] n;

  always_comb begin
    n = 4'd0;
    for (int i = 0; i < 3; i++) begin
      n = n + {3'b0, top_i[i]} + {3'b0, bot_i[i]};
    end
    n = n + {3'b0, mid_i[0]} + {3'b0, mid_i[2]};
    next_o = (n == LIFE_BIRTH) |
             (mid_i[1] & (n == LIFE_SURVIVE));
  end

endmodule

// File: rtl/conware_row_engine.sv
// Streams grid rows in, keeps a three-row window and
// emits the next generation one row at a time.
module conware_row_engine
  import conware_row_engine_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] gen_count,
  output logic             busy
);

  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  state_e           state_q, state_d;
  logic [RW-1:0]    row_cnt_q, row_cnt_d;
  logic [WIDTH-1:0] above_q, above_d;
  logic [WIDTH-1:0] mid_q, mid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] gen_q, gen_d;
  logic             busy_q, busy_d;

  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] below;
  logic [WIDTH-1:0] nxt_row;
  logic [WIDTH+1:0] a_pad, m_pad, b_pad;

  // The row below is all-dead while flushing the last row.
  assign below = (state_q == ST_FLUSH) ? '0 : in_data;
  assign a_pad = {1'b0, above_q, 1'b0};
  assign m_pad = {1'b0, mid_q, 1'b0};
  assign b_pad = {1'b0, below, 1'b0};

  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    life_cell u_cell (
      .top_i  (a_pad[c+2:c]),
      .mid_i  (m_pad[c+2:c]),
      .bot_i  (b_pad[c+2:c]),
      .next_o (nxt_row[c])
    );
  end

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = rstn && (state_q == ST_RUN) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    above_d     = above_q;
    mid_d       = mid_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    gen_d       = gen_q;
    busy_d      = busy_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      if (out_last_q) busy_d = 1'b0;
    end

    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (row_cnt_q == '0) begin
            above_d = '0;
            mid_d   = in_data;
            busy_d  = 1'b1;
          end else begin
            out_data_d  = nxt_row;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            above_d     = mid_q;
            mid_d       = in_data;
          end
          if (row_cnt_q == LAST_ROW) begin
            state_d   = ST_FLUSH;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          out_data_d  = nxt_row;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          gen_d       = gen_q + 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      row_cnt_q   <= '0;
      above_q     <= '0;
      mid_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      gen_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      above_q     <= above_d;
      mid_q       <= mid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      gen_q       <= gen_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign gen_count = gen_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conware_row_engine.sv
// Directed bench for conware_row_engine: frame table,
// backpressure, random drain, mid-frame reset, HEIGHT=1.
module tb_conware_row_engine;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [31:0] gen_count;
  logic        busy;

  logic [7:0]  h1_in_data = '0;
  logic        h1_in_valid = 1'b0;
  logic        h1_in_ready;
  logic [7:0]  h1_out_data;
  logic        h1_out_valid;
  logic        h1_out_ready = 1'b1;
  logic        h1_out_last;
  logic [31:0] h1_gen;
  logic        h1_busy;

  int checks = 0;
  int errors = 0;
  int exp_gen = 0;
  logic rnd_en = 1'b0;
  logic [8:0] mq[$];

  typedef struct packed {
    logic [63:0] in_rows;
    logic [63:0] exp_rows;
  } vec_t;

  vec_t vecs[4];

  localparam logic [63:0] BLINK_IN  = 64'h00000000_1C000000;
  localparam logic [63:0] BLINK_OUT = 64'h00000008_08080000;
  localparam logic [63:0] EDGE_IN   = 64'h00000000_000000FF;
  localparam logic [63:0] EDGE_OUT  = 64'h00000000_00007E7E;

  always #5 clk = ~clk;

  conware_row_engine #(.WIDTH(8), .HEIGHT(8), .CNT_W(32)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .gen_count (gen_count),
    .busy      (busy)
  );

  conware_row_engine #(.WIDTH(8), .HEIGHT(1), .CNT_W(32)) u_h1 (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (h1_in_data),
    .in_valid  (h1_in_valid),
    .in_ready  (h1_in_ready),
    .out_data  (h1_out_data),
    .out_valid (h1_out_valid),
    .out_ready (h1_out_ready),
    .out_last  (h1_out_last),
    .gen_count (h1_gen),
    .busy      (h1_busy)
  );

  always @(posedge clk) begin
    if (rstn && out_valid && out_ready)
      mq.push_back({out_last, out_data});
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_row(input logic [7:0] d);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    do begin
      @(posedge clk);
      t++;
    end while (!in_ready && t < 500);
    if (!in_ready) chk("send_timeout", 0, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] rows);
    for (int r = 0; r < 8; r++) send_row(rows[8*r +: 8]);
  endtask

  task automatic wait_q(input int n);
    int t = 0;
    while (mq.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (mq.size() < n) chk("out_timeout", mq.size(), n);
  endtask

  task automatic cmp_frame(input string nm, input logic [63:0] exp);
    logic [8:0] e;
    for (int r = 0; r < 8; r++) begin
      e = (mq.size() > 0) ? mq.pop_front() : 9'h1FF;
      chk($sformatf("%s_row%0d", nm, r), 32'(e[7:0]), 32'(exp[8*r +: 8]));
      chk($sformatf("%s_last%0d", nm, r), 32'(e[8]), 32'(r == 7));
    end
  endtask

  initial begin
    vecs[0] = '{in_rows: BLINK_IN, exp_rows: BLINK_OUT};
    vecs[1] = '{in_rows: 64'h0000000000000303,
                exp_rows: 64'h0000000000000303};
    vecs[2] = '{in_rows: EDGE_IN, exp_rows: EDGE_OUT};
    vecs[3] = '{in_rows: 64'h0, exp_rows: 64'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].in_rows);
      wait_q(8);
      exp_gen++;
      cmp_frame($sformatf("vec%0d", v), vecs[v].exp_rows);
      chk($sformatf("vec%0d_gen", v), gen_count, 32'(exp_gen));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 0);
    end

    @(posedge clk);
    #1 out_ready = 1'b0;
    send_row(EDGE_IN[7:0]);
    send_row(EDGE_IN[15:8]);
    in_data  = EDGE_IN[23:16];
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'h7E);
      chk("bp_last", 32'(out_last), 0);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int r = 2; r < 8; r++) send_row(EDGE_IN[8*r +: 8]);
    wait_q(8);
    exp_gen++;
    cmp_frame("bp", EDGE_OUT);
    chk("bp_gen", gen_count, 32'(exp_gen));

    rnd_en = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(BLINK_IN);
    wait_q(24);
    rnd_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (4) @(negedge clk);
    exp_gen += 3;
    chk("rnd_count", mq.size(), 24);
    for (int f = 0; f < 3; f++) cmp_frame($sformatf("rnd%0d", f), BLINK_OUT);
    chk("rnd_gen", gen_count, 32'(exp_gen));

    for (int r = 0; r < 5; r++) send_row(BLINK_IN[8*r +: 8]);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_gen", gen_count, 0);
    rstn = 1'b1;
    mq.delete();
    send_frame(BLINK_IN);
    wait_q(8);
    cmp_frame("mrst", BLINK_OUT);
    chk("mrst_gen2", gen_count, 1);

    begin
      int t = 0;
      h1_in_data  = 8'h0E;
      h1_in_valid = 1'b1;
      do begin
        @(posedge clk);
        t++;
      end while (!h1_in_ready && t < 100);
      if (!h1_in_ready) chk("h1_in_timeout", 0, 1);
      #1 h1_in_valid = 1'b0;
      t = 0;
      while (!h1_out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("h1_valid", 32'(h1_out_valid), 1);
      chk("h1_data", 32'(h1_out_data), 32'h04);
      chk("h1_last", 32'(h1_out_last), 1);
      chk("h1_gen", h1_gen, 1);
      @(negedge clk);
      chk("h1_valid_after", 32'(h1_out_valid), 0);
      chk("h1_busy_after", 32'(h1_busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
